// File: rtl/gpu_pkg.sv
// gpu_pkg: widths, pixel record and fb_writer state encoding shared across the gpu blocks.
// Rev 1.0
`default_nettype none

package gpu_pkg;

    localparam int COLOR_W = 24;
    localparam int COORD_W = 8;
    localparam int ADDR_W  = 16;

    typedef enum logic [1:0] {
        FBW_IDLE  = 2'd0,
        FBW_WRITE = 2'd1,
        FBW_CLEAR = 2'd2
    } fbw_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] py;
        logic [COORD_W-1:0] px;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    localparam int PIXEL_W = $bits(pixel_t);

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO, power-of-two depth, wrap-bit pointers for full/empty.
// Rev 1.0
`default_nettype none

module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/fb_writer.sv
// fb_writer: queues rasterizer pixels and writes them (or a full-screen clear) to the framebuffer.
// Rev 1.0
`default_nettype none

module fb_writer
    import gpu_pkg::*;
#(
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] CLR_LAST   = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COLOR_W-1:0] pixel_color,
    input  logic               draw_done,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic               mem_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    input  logic               ovf_clr
);

    fbw_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;
    logic               clr_pend_q, clr_pend_d;
    logic               done_pend_q, done_pend_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         drop_q, drop_d;

    logic               load;
    logic               enter_clear;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;
    logic [PIXEL_W-1:0] fifo_rdata;
    pixel_t             head;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({py, px, pixel_color}),
        .pop_i   (load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head      = pixel_t'(fifo_rdata);
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign fifo_push = pixel_valid && (!fifo_full || load);
    assign drop      = pixel_valid && fifo_full && !load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FBW_IDLE;
        else       state_q <= state_d;
    end

    // Queued pixels drain ahead of a pending clear, so the clear starts only once the FIFO is empty.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        enter_clear = 1'b0;
        case (state_q)
            FBW_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = FBW_WRITE;
                end else if (clr_pend_q) begin
                    enter_clear = 1'b1;
                    state_d     = FBW_CLEAR;
                end
            end
            FBW_WRITE: begin
                if (mem_ready) begin
                    if (!fifo_empty) load = 1'b1;
                    else             state_d = FBW_IDLE;
                end
            end
            FBW_CLEAR: begin
                if (mem_ready && (addr_q == CLR_LAST)) state_d = FBW_IDLE;
            end
            default: state_d = FBW_IDLE;
        endcase
    end

    always_comb begin
        mem_we     = (state_q != FBW_IDLE);
        busy       = (state_q != FBW_IDLE) || !fifo_empty || clr_pend_q;
        frame_done = (state_q == FBW_IDLE) && fifo_empty && !clr_pend_q && done_pend_q;
    end

    // The output register doubles as the clear address counter and latched clear colour.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (load) begin
            addr_d = {head.py, head.px};
            data_d = head.color;
        end else if (enter_clear) begin
            addr_d = '0;
            data_d = clear_color;
        end else if ((state_q == FBW_CLEAR) && mem_ready) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        clr_pend_d  = enter_clear ? 1'b0
                                  : (clr_pend_q || (clear_start && (state_q != FBW_CLEAR)));
        done_pend_d = draw_done || (done_pend_q && !frame_done);
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            clr_pend_q  <= 1'b0;
            done_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            clr_pend_q  <= clr_pend_d;
            done_pend_q <= done_pend_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_writer.sv
// tb_fb_writer: directed and randomized checks of fb_writer against a queue-based reference model.
// Rev 1.0
`default_nettype none

module tb_fb_writer;

    localparam int          DEPTH    = 8;
    localparam logic [15:0] CLR_LAST = 16'h000F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [7:0]  px = '0;
    logic [7:0]  py = '0;
    logic [23:0] pixel_color = '0;
    logic        draw_done = 1'b0;
    logic        clear_start = 1'b0;
    logic [23:0] clear_color = '0;
    logic        mem_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [7:0]  drop_cnt;

    fb_writer #(
        .FIFO_DEPTH (DEPTH),
        .CLR_LAST   (CLR_LAST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .px          (px),
        .py          (py),
        .pixel_color (pixel_color),
        .draw_done   (draw_done),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: pixel queue, a "holding a pixel" flag, and a clear sweep position.
    typedef struct packed {
        logic [15:0] a;
        logic [23:0] d;
    } wr_t;

    wr_t         q[$];
    bit          m_out_v, m_clr, m_cpend, m_dpend, m_ovf;
    logic [15:0] m_out_a, m_clr_a;
    logic [23:0] m_out_d, m_clr_c;
    int          m_drops;

    int          vecs = 0;
    int          errs = 0;
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          wr_at_fd = 0;
    wr_t         wlog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_out_v = 0; m_clr = 0; m_cpend = 0; m_dpend = 0; m_ovf = 0;
        m_out_a = '0; m_out_d = '0; m_clr_a = '0; m_clr_c = '0;
        m_drops = 0;
    endfunction

    function automatic void model_step();
        bit  idle, hs, fd, enter, drop, was_clr;
        wr_t e;
        if (reset) begin
            model_reset();
            return;
        end
        idle    = !m_out_v && !m_clr;
        hs      = !idle && mem_ready;
        fd      = idle && (q.size() == 0) && !m_cpend && m_dpend;
        was_clr = m_clr;
        enter   = 0;
        if (m_clr) begin
            if (hs) begin
                if (m_clr_a == CLR_LAST) m_clr = 0;
                else                     m_clr_a = m_clr_a + 16'd1;
            end
        end else if (m_out_v) begin
            if (hs) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_out_a = e.a; m_out_d = e.d;
                end else begin
                    m_out_v = 0;
                end
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_out_a = e.a; m_out_d = e.d; m_out_v = 1;
        end else if (m_cpend) begin
            m_clr = 1; m_clr_a = '0; m_clr_c = clear_color; enter = 1;
        end
        drop = 0;
        if (pixel_valid) begin
            if (q.size() < DEPTH) q.push_back('{a: {py, px}, d: pixel_color});
            else                  drop = 1;
        end
        if (ovf_clr) begin
            m_ovf = 0;
            m_drops = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
        end
        m_cpend = enter ? 0 : (m_cpend || (clear_start && !was_clr));
        m_dpend = draw_done || (m_dpend && !fd);
    endfunction

    task automatic compare();
        bit idle;
        idle = !m_out_v && !m_clr;
        check("mem_we", 32'(mem_we), 32'(!idle));
        if (!idle) begin
            check("mem_addr",  32'(mem_addr),  32'(m_clr ? m_clr_a : m_out_a));
            check("mem_wdata", 32'(mem_wdata), 32'(m_clr ? m_clr_c : m_out_d));
        end
        check("busy", 32'(busy), 32'(!idle || (q.size() > 0) || m_cpend));
        check("frame_done", 32'(frame_done),
              32'(idle && (q.size() == 0) && !m_cpend && m_dpend));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    // Inputs are driven at the falling edge before calling tick; pulses are cleared afterwards.
    task automatic tick();
        if (mem_we === 1'b1 && mem_ready) begin
            wr_cnt++;
            wlog.push_back('{a: mem_addr, d: mem_wdata});
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            wr_at_fd = wr_cnt;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        pixel_valid = 0; draw_done = 0; clear_start = 0; ovf_clr = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic put_pixel(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
        pixel_valid = 1; px = x; py = y; pixel_color = c;
    endtask

    initial begin
        int w0, f0, base;
        bit found;

        model_reset();
        @(negedge clk);
        repeat (3) tick();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 0;
        tick();

        // Single pixel, then frame_done after the write.
        mem_ready = 1;
        w0 = wr_cnt; f0 = fd_cnt;
        put_pixel(8'd10, 8'd20, 24'hFF0000);
        draw_done = 1;
        repeat (6) tick();
        check("single_writes", 32'(wr_cnt - w0), 32'd1);
        check("single_addr", 32'(wlog[wlog.size()-1].a), 32'h140A);
        check("single_data", 32'(wlog[wlog.size()-1].d), 32'hFF0000);
        check("single_fd", 32'(fd_cnt - f0), 32'd1);
        check("fd_after_write", 32'(wr_at_fd - w0), 32'd1);

        // Stall for 5 cycles: outputs hold, exactly one write.
        mem_ready = 0;
        w0 = wr_cnt;
        put_pixel(8'd5, 8'd3, 24'hABCDEF);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", 32'(mem_addr), 32'h0305);
            check("stall_data", 32'(mem_wdata), 32'hABCDEF);
            tick();
        end
        check("stall_nowrite", 32'(wr_cnt - w0), 32'd0);
        mem_ready = 1;
        tick();
        wait_idle("stall_idle");
        check("stall_writes", 32'(wr_cnt - w0), 32'd1);

        // Overflow: 12 pixels with the memory stalled.
        mem_ready = 0;
        w0 = wr_cnt;
        for (int i = 0; i < 12; i++) begin
            put_pixel(8'(i), 8'd40, 24'(i * 3));
            tick();
        end
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_cnt), 32'd3);
        ovf_clr = 1;
        tick();
        check("ovfclr_flag", 32'(overflow), 32'd0);
        check("ovfclr_drops", 32'(drop_cnt), 32'd0);
        mem_ready = 1;
        wait_idle("ovf_idle");
        check("ovf_writes", 32'(wr_cnt - w0), 32'd9);

        // Clear of addresses 0..15, with one pixel arriving mid-clear.
        w0 = wr_cnt;
        base = wlog.size();
        clear_color = 24'h00FF00;
        clear_start = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) put_pixel(8'd1, 8'd2, 24'h123456);
            tick();
        end
        wait_idle("clear_idle");
        check("clear_writes", 32'(wr_cnt - w0), 32'd17);
        if (wlog.size() >= base + 17) begin
            for (int i = 0; i < 16; i++) begin
                check("clear_addr", 32'(wlog[base+i].a), 32'(i));
                check("clear_data", 32'(wlog[base+i].d), 32'h00FF00);
            end
            check("midclr_addr", 32'(wlog[base+16].a), 32'h0201);
            check("midclr_data", 32'(wlog[base+16].d), 32'h123456);
        end

        // Reset while the clear is at address 7.
        clear_color = 24'h0000FF;
        clear_start = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_we === 1'b1 && mem_addr == 16'd7) found = 1;
            else tick();
        end
        check("reach_addr7", 32'(found), 32'd1);
        reset = 1;
        model_reset();
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        w0 = wr_cnt;
        tick();
        reset = 0;
        repeat (6) tick();
        check("abort_nowrite", 32'(wr_cnt - w0), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            mem_ready   = (n < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            pixel_valid = ($urandom_range(0, 1) == 1);
            px          = 8'($urandom);
            py          = 8'($urandom);
            pixel_color = 24'($urandom);
            clear_start = ($urandom_range(0, 63) == 0);
            clear_color = 24'($urandom);
            draw_done   = ($urandom_range(0, 15) == 0);
            ovf_clr     = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 999) == 0) begin
                reset = 1;
                model_reset();
                tick();
                reset = 0;
            end else begin
                tick();
            end
        end
        mem_ready = 1;
        wait_idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
